// File: rtl/spi_mem_sequencer.sv
// Transaction sequencer above the SPI byte engine: one read/write request becomes a 25xx-class byte frame.
// Optional WIP status polling after writes is compiled in with `define SPI_SEQ_WIP_POLL_EN.
module spi_mem_sequencer #(
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02,
`ifdef SPI_SEQ_WIP_POLL_EN
    parameter logic [7:0] CMD_RDSR  = 8'h05,
    parameter int unsigned POLL_MAX = 1023,
`endif
    parameter logic [7:0] CMD_WREN  = 8'h06
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        eng_start,
    output logic        eng_continued,
    output logic [7:0]  eng_tx,
    input  logic [7:0]  eng_rx,
    input  logic        eng_ready
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, ACK, DONE, NEXT,
`ifdef SPI_SEQ_WIP_POLL_EN
        POLL,
`endif
        RESP
    } state_t;

    state_t      state_r;
    logic        wr_r;
    logic [15:0] addr_r;
    logic [7:0]  wdata_r;
    logic [2:0]  idx_r;
    logic [8:0]  cur_byte_s;
    logic [2:0]  last_idx_s;

`ifdef SPI_SEQ_WIP_POLL_EN
    localparam logic [9:0] POLL_LAST = 10'(POLL_MAX - 1);
    logic [9:0]  poll_cnt_r;
    logic        wip_r;
`else
    assign rsp_err = 1'b0;
`endif

    // Returns {continued, byte} for a frame position; writes lead with a standalone WREN.
    function automatic logic [8:0] queue_byte(input logic wr, input logic [2:0] idx,
                                              input logic [15:0] addr, input logic [7:0] wdata);
        logic [8:0] b;
        b = 9'h000;
        if (wr) begin
            case (idx)
                3'd0:    b = {1'b0, CMD_WREN};
                3'd1:    b = {1'b1, CMD_WRITE};
                3'd2:    b = {1'b1, addr[15:8]};
                3'd3:    b = {1'b1, addr[7:0]};
                3'd4:    b = {1'b0, wdata};
`ifdef SPI_SEQ_WIP_POLL_EN
                3'd5:    b = {1'b1, CMD_RDSR};
                3'd6:    b = {1'b0, 8'hFF};
`endif
                default: b = 9'h000;
            endcase
        end else begin
            case (idx)
                3'd0:    b = {1'b1, CMD_READ};
                3'd1:    b = {1'b1, addr[15:8]};
                3'd2:    b = {1'b1, addr[7:0]};
                3'd3:    b = {1'b0, 8'hFF};
                default: b = 9'h000;
            endcase
        end
        return b;
    endfunction

    assign cur_byte_s = queue_byte(wr_r, idx_r, addr_r, wdata_r);
    assign last_idx_s = wr_r ? 3'd4 : 3'd3;

    // Frame sequencing FSM with registered handshake and engine outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            wr_r          <= 1'b0;
            addr_r        <= 16'h0000;
            wdata_r       <= 8'h00;
            idx_r         <= 3'd0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 8'h00;
            busy          <= 1'b0;
            eng_start     <= 1'b0;
            eng_continued <= 1'b0;
            eng_tx        <= 8'h00;
`ifdef SPI_SEQ_WIP_POLL_EN
            rsp_err       <= 1'b0;
            poll_cnt_r    <= 10'd0;
            wip_r         <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        wr_r      <= cmd_write;
                        addr_r    <= cmd_addr;
                        wdata_r   <= cmd_wdata;
                        idx_r     <= 3'd0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef SPI_SEQ_WIP_POLL_EN
                        poll_cnt_r <= 10'd0;
`endif
                        state_r   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (eng_ready) begin
                        eng_start     <= 1'b1;
                        eng_tx        <= cur_byte_s[7:0];
                        eng_continued <= cur_byte_s[8];
                        state_r       <= ACK;
                    end
                end
                ACK: begin
                    eng_start <= 1'b0;
                    if (!eng_ready) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (eng_ready) begin
                        if (!wr_r && idx_r == 3'd3) begin
                            rsp_rdata <= eng_rx;
                        end
`ifdef SPI_SEQ_WIP_POLL_EN
                        if (wr_r && idx_r == 3'd6) begin
                            wip_r <= eng_rx[0];
                        end
`endif
                        state_r <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_r == last_idx_s) begin
`ifdef SPI_SEQ_WIP_POLL_EN
                        if (wr_r) begin
                            state_r <= POLL;
                        end else begin
                            rsp_valid <= 1'b1;
                            state_r   <= RESP;
                        end
`else
                        rsp_valid <= 1'b1;
                        state_r   <= RESP;
`endif
                    end
`ifdef SPI_SEQ_WIP_POLL_EN
                    else if (idx_r == 3'd6) begin
                        if (!wip_r) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            state_r   <= RESP;
                        end else if (poll_cnt_r == POLL_LAST) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            state_r   <= RESP;
                        end else begin
                            poll_cnt_r <= poll_cnt_r + 10'd1;
                            idx_r      <= 3'd5;
                            state_r    <= ISSUE;
                        end
                    end
`endif
                    else begin
                        idx_r   <= idx_r + 3'd1;
                        state_r <= ISSUE;
                    end
                end
`ifdef SPI_SEQ_WIP_POLL_EN
                POLL: begin
                    idx_r   <= 3'd5;
                    state_r <= ISSUE;
                end
`endif
                RESP: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
`ifdef SPI_SEQ_WIP_POLL_EN
                    rsp_err   <= 1'b0;
`endif
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// Directed bench for spi_mem_sequencer: behavioural byte engine plus byte/response scoreboards.
module tb_spi_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        eng_start;
    logic        eng_continued;
    logic [7:0]  eng_tx;
    logic [7:0]  eng_rx = 8'h00;
    logic        eng_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int rsp_cnt = 0;
    logic       hold = 1'b0;
    logic [7:0] rx_value = 8'h00;

    logic [8:0] exp_bytes[$];
    logic [8:0] exp_rsp[$];

    spi_mem_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .eng_start(eng_start), .eng_continued(eng_continued), .eng_tx(eng_tx),
        .eng_rx(eng_rx), .eng_ready(eng_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_read(input logic [15:0] a, input logic [7:0] rd);
        exp_bytes.push_back({1'b1, 8'h03});
        exp_bytes.push_back({1'b1, a[15:8]});
        exp_bytes.push_back({1'b1, a[7:0]});
        exp_bytes.push_back({1'b0, 8'hFF});
        exp_rsp.push_back({1'b0, rd});
    endtask

    task automatic push_write(input logic [15:0] a, input logic [7:0] wd, input logic [7:0] held);
        exp_bytes.push_back({1'b0, 8'h06});
        exp_bytes.push_back({1'b1, 8'h02});
        exp_bytes.push_back({1'b1, a[15:8]});
        exp_bytes.push_back({1'b1, a[7:0]});
        exp_bytes.push_back({1'b0, wd});
        exp_rsp.push_back({1'b0, held});
    endtask

    // Drive one request at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic wr, input logic [15:0] a, input logic [7:0] wd);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (rsp_cnt >= target) break;
            @(negedge clk);
        end
        chk(tag, 32'(rsp_cnt >= target), 32'd1);
    endtask

    // Byte engine model: accepts a start while idle, stays busy 3 cycles, returns a byte.
    initial begin
        logic [7:0] tx_s;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && eng_start && eng_ready) begin
                tx_s = eng_tx;
                if (exp_bytes.size() == 0) begin
                    chk("byte_extra", {23'd0, eng_continued, eng_tx}, 32'h0);
                end else begin
                    e = exp_bytes.pop_front();
                    chk("byte", {23'd0, eng_continued, eng_tx}, {23'd0, e});
                end
                eng_ready = 1'b0;
                repeat (3) @(negedge clk);
                eng_rx = (tx_s == 8'hFF) ? rx_value : ~tx_s;
                eng_ready = 1'b1;
            end else begin
                eng_ready = !hold;
            end
        end
    end

    // Start pulse counter and response scoreboard.
    initial begin
        logic [8:0] r;
        forever begin
            @(negedge clk);
            if (eng_start) start_cnt++;
            if (rsp_valid) begin
                rsp_cnt++;
                chk("busy_at_rsp", {31'd0, busy}, 32'd1);
                if (exp_rsp.size() == 0) begin
                    chk("rsp_extra", {23'd0, rsp_err, rsp_rdata}, 32'h1FF);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp", {23'd0, rsp_err, rsp_rdata}, {23'd0, r});
                end
            end
        end
    end

    initial begin
        int base;
        int rsp_at;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_outs", {19'd0, rsp_valid, rsp_err, busy, eng_start, eng_continued, eng_tx},
            32'd0);
        chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        rst_n = 1'b1;

        // Read 0x1234 with first-start latency checks
        rx_value = 8'h5A;
        push_read(16'h1234, 8'h5A);
        base = start_cnt;
        send(1'b0, 16'h1234, 8'h00);
        chk("lat_issue", {29'd0, eng_start, busy, cmd_ready}, 32'b010);
        @(negedge clk);
        chk("lat_start", {22'd0, eng_start, eng_continued, eng_tx}, {22'd0, 2'b11, 8'h03});
        wait_rsp(1, "read_timeout");
        @(negedge clk);
        chk("read_starts", 32'(start_cnt - base), 32'd4);
        chk("idle_after", {30'd0, busy, cmd_ready}, 32'b01);

        // Write 0xA5 to 0x00FF; rdata holds previous value
        push_write(16'h00FF, 8'hA5, 8'h5A);
        base = start_cnt;
        send(1'b1, 16'h00FF, 8'hA5);
        wait_rsp(2, "write_timeout");
        @(negedge clk);
        chk("write_starts", 32'(start_cnt - base), 32'd5);

        // Engine stalled for 20 cycles before first byte
        hold = 1'b1;
        rx_value = 8'h33;
        push_read(16'hBEEF, 8'h33);
        base = start_cnt;
        send(1'b0, 16'hBEEF, 8'h00);
        repeat (20) @(negedge clk);
        chk("stall_no_start", 32'(start_cnt - base), 32'd0);
        hold = 1'b0;
        wait_rsp(3, "stall_timeout");
        @(negedge clk);
        chk("stall_starts", 32'(start_cnt - base), 32'd4);

        // cmd_valid held high with new data while busy
        rx_value = 8'h44;
        push_read(16'h0102, 8'h44);
        push_write(16'h0304, 8'h77, 8'h44);
        send(1'b0, 16'h0102, 8'h00);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0304; cmd_wdata = 8'h77;
        rsp_at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                rsp_at = rsp_cnt;
                break;
            end
        end
        chk("b2b_accept_after_rsp", 32'(rsp_at), 32'd4);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(5, "b2b_timeout");

        // Reset during DONE of byte 2
        @(negedge clk);
        exp_bytes.push_back({1'b1, 8'h03});
        exp_bytes.push_back({1'b1, 8'h56});
        exp_bytes.push_back({1'b1, 8'h78});
        base = start_cnt;
        send(1'b0, 16'h5678, 8'h00);
        for (int i = 0; i < 200; i++) begin
            if (start_cnt - base >= 3) break;
            @(negedge clk);
        end
        chk("mid_reached", 32'(start_cnt - base), 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_outs", {19'd0, rsp_valid, rsp_err, busy, eng_start, eng_continued, eng_tx},
            32'd0);
        chk("mid_rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        repeat (6) @(negedge clk);
        chk("mid_rst_no_rsp", 32'(rsp_cnt), 32'd5);
        exp_bytes.delete();
        rst_n = 1'b1;

        // Clean read after reset starts from byte 0
        rx_value = 8'hC3;
        push_read(16'h1357, 8'hC3);
        base = start_cnt;
        send(1'b0, 16'h1357, 8'h00);
        wait_rsp(6, "post_rst_timeout");
        @(negedge clk);
        chk("post_rst_starts", 32'(start_cnt - base), 32'd4);

        repeat (5) @(negedge clk);
        chk("bytes_drained", 32'(exp_bytes.size()), 32'd0);
        chk("rsp_drained", 32'(exp_rsp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
